// File: rtl/simple_alu_ins_analyser.sv
// Execute-stage core for the R/I/J pipeline.
// This stage decodes the incoming instruction and picks the ALU operands.
// It latches A, B, IR and the ALU op on the falling clock edge.
// The ALU result and its zero and overflow flags are combinational.
module simple_alu_ins_analyser (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] NPCi,
  input  logic [31:0] Ai,
  input  logic [31:0] Bi,
  input  logic [31:0] Immi,
  output logic        cond,
  output logic [31:0] ALUo,
  output logic        ZFo,
  output logic        OFo,
  output logic [31:0] Bo,
  output logic [31:0] IRo,
  output logic        isALUR,
  output logic        isBranch
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_e;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] ir_q, ir_d;
  alu_op_e     alu_op_q, alu_op_d;

  logic        in_is_r;
  logic        in_is_branch;
  alu_op_e     in_op;

  logic [31:0] alu_f;
  logic        alu_of;
  logic [31:0] sum_ab;
  logic [31:0] diff_ab;

  // Decode the incoming word. Operand selection must use this decode, not the stale latched IR.
  always_comb begin
    in_is_r      = (IRi[31:26] == 6'b000000);
    in_is_branch = (IRi[31:26] == 6'b000100) || (IRi[31:26] == 6'b000101);
    in_op        = OP_ADD;
    if (in_is_r) begin
      case (IRi[5:0])
        6'b100000, 6'b100001: in_op = OP_ADD;
        6'b100010, 6'b100011: in_op = OP_SUB;
        6'b100100:            in_op = OP_AND;
        6'b100101:            in_op = OP_OR;
        6'b100110:            in_op = OP_XOR;
        6'b100111:            in_op = OP_NOR;
        6'b101010:            in_op = OP_SLT;
        6'b101011:            in_op = OP_SLTU;
        default:              in_op = OP_ADD;
      endcase
    end else begin
      case (IRi[31:26])
        6'b001100: in_op = OP_AND;
        6'b001101: in_op = OP_OR;
        6'b001110: in_op = OP_XOR;
        6'b001010: in_op = OP_SLT;
        6'b001011: in_op = OP_SLTU;
        default:   in_op = OP_ADD;
      endcase
    end
  end

  // Next-state values for the stage registers.
  // Reset clears every register and takes priority over a load.
  // Branches add NPC to the immediate scaled by 4.
  always_comb begin
    a_d      = Ai;
    b_d      = Immi;
    ir_d     = IRi;
    alu_op_d = in_op;
    if (in_is_branch) begin
      a_d = NPCi;
      b_d = {Immi[29:0], 2'b00};
    end else if (in_is_r) begin
      b_d = Bi;
    end
    if (rst) begin
      a_d      = '0;
      b_d      = '0;
      ir_d     = '0;
      alu_op_d = OP_AND;
    end
  end

  // The stage registers update on the falling edge to match the pipeline's latch timing.
  always_ff @(negedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    ir_q     <= ir_d;
    alu_op_q <= alu_op_d;
  end

  // Combinational ALU. Overflow is only meaningful for ADD and SUB, so every other op forces it to 0.
  always_comb begin
    sum_ab  = a_q + b_q;
    diff_ab = a_q - b_q;
    alu_f   = '0;
    alu_of  = 1'b0;
    case (alu_op_q)
      OP_AND:  alu_f = a_q & b_q;
      OP_OR:   alu_f = a_q | b_q;
      OP_ADD: begin
        alu_f  = sum_ab;
        alu_of = (a_q[31] == b_q[31]) && (sum_ab[31] != a_q[31]);
      end
      OP_XOR:  alu_f = a_q ^ b_q;
      OP_NOR:  alu_f = ~(a_q | b_q);
      OP_SLT:  alu_f = {31'b0, ($signed(a_q) < $signed(b_q))};
      OP_SUB: begin
        alu_f  = diff_ab;
        alu_of = (a_q[31] != b_q[31]) && (diff_ab[31] != a_q[31]);
      end
      OP_SLTU: alu_f = {31'b0, (a_q < b_q)};
      default: alu_f = '0;
    endcase
  end

  // Output assignments.
  // cond comes straight from the Ai input so a branch entering the stage can be resolved in the same half-cycle.
  // The class flags decode the latched IR.
  always_comb begin
    cond     = (Ai == 32'd0);
    ALUo     = alu_f;
    ZFo      = (alu_f == 32'd0);
    OFo      = alu_of;
    Bo       = b_q;
    IRo      = ir_q;
    isALUR   = (ir_q[31:26] == 6'b000000);
    isBranch = (ir_q[31:26] == 6'b000100) || (ir_q[31:26] == 6'b000101);
  end

endmodule

// File: tb/tb_simple_alu_ins_analyser.sv
// Directed testbench for simple_alu_ins_analyser.
// Inputs change after the rising edge, the DUT latches on the falling edge,
// and outputs are sampled 1 ns after the falling edge.
module tb_simple_alu_ins_analyser;

  logic        clk;
  logic        rst;
  logic [31:0] IRi, NPCi, Ai, Bi, Immi;
  logic        cond;
  logic [31:0] ALUo;
  logic        ZFo, OFo;
  logic [31:0] Bo, IRo;
  logic        isALUR, isBranch;

  int checksDone;
  int checksPassed;

  simple_alu_ins_analyser dut (
    .clk      (clk),
    .rst      (rst),
    .IRi      (IRi),
    .NPCi     (NPCi),
    .Ai       (Ai),
    .Bi       (Bi),
    .Immi     (Immi),
    .cond     (cond),
    .ALUo     (ALUo),
    .ZFo      (ZFo),
    .OFo      (OFo),
    .Bo       (Bo),
    .IRo      (IRo),
    .isALUR   (isALUR),
    .isBranch (isBranch)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Drive one set of stage inputs after a rising edge.
  // Then let the falling edge latch them and settle just past it.
  task automatic applyStimulus(input logic r, input logic [31:0] ir, input logic [31:0] npc,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    @(posedge clk);
    rst = r; IRi = ir; NPCi = npc; Ai = a; Bi = b; Immi = imm;
    @(negedge clk);
    #1;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    checksDone = 0; checksPassed = 0;
    rst = 1'b1; IRi = '0; NPCi = '0; Ai = '0; Bi = '0; Immi = '0;

    // Reset while a valid add sits on the inputs.
    applyStimulus(1'b1, 32'h012A4020, 32'h0, 32'd5, 32'd7, 32'd9);
    checkOutput("rst_alu", ALUo, 32'h0);
    checkOutput("rst_zf", {31'b0, ZFo}, 32'd1);
    checkOutput("rst_of", {31'b0, OFo}, 32'd0);
    checkOutput("rst_ir", IRo, 32'h0);
    checkOutput("rst_b", Bo, 32'h0);
    checkOutput("rst_isalur", {31'b0, isALUR}, 32'd1);
    checkOutput("rst_isbr", {31'b0, isBranch}, 32'd0);

    // R-type add with signed overflow.
    applyStimulus(1'b0, 32'h012A4020, 32'h4, 32'h7FFFFFFF, 32'h1, 32'h55);
    checkOutput("add_alu", ALUo, 32'h80000000);
    checkOutput("add_of", {31'b0, OFo}, 32'd1);
    checkOutput("add_zf", {31'b0, ZFo}, 32'd0);
    checkOutput("add_isalur", {31'b0, isALUR}, 32'd1);
    checkOutput("add_b", Bo, 32'h1);
    checkOutput("add_ir", IRo, 32'h012A4020);

    // sub 5-5 gives zero.
    applyStimulus(1'b0, 32'h012A4022, 32'h4, 32'd5, 32'd5, 32'h0);
    checkOutput("sub_alu", ALUo, 32'h0);
    checkOutput("sub_zf", {31'b0, ZFo}, 32'd1);
    checkOutput("sub_of", {31'b0, OFo}, 32'd0);

    // sub with overflow: 0x80000000 - 1.
    applyStimulus(1'b0, 32'h012A4023, 32'h4, 32'h80000000, 32'h1, 32'h0);
    checkOutput("subo_alu", ALUo, 32'h7FFFFFFF);
    checkOutput("subo_of", {31'b0, OFo}, 32'd1);

    // slt is signed, so -1 < 1.
    applyStimulus(1'b0, 32'h012A402A, 32'h4, 32'hFFFFFFFF, 32'h1, 32'h0);
    checkOutput("slt_alu", ALUo, 32'h1);
    checkOutput("slt_of", {31'b0, OFo}, 32'd0);

    // sltu is unsigned, so 0xFFFFFFFF is not below 1.
    applyStimulus(1'b0, 32'h012A402B, 32'h4, 32'hFFFFFFFF, 32'h1, 32'h0);
    checkOutput("sltu_alu", ALUo, 32'h0);
    checkOutput("sltu_zf", {31'b0, ZFo}, 32'd1);

    // nor of zeros, then an R-type and / or / xor pass.
    applyStimulus(1'b0, 32'h012A4027, 32'h4, 32'h0, 32'h0, 32'h0);
    checkOutput("nor_alu", ALUo, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'h012A4024, 32'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
    checkOutput("and_alu", ALUo, 32'hF000F000);
    applyStimulus(1'b0, 32'h012A4025, 32'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
    checkOutput("or_alu", ALUo, 32'hFFF0FFF0);
    applyStimulus(1'b0, 32'h012A4026, 32'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
    checkOutput("xor_alu", ALUo, 32'h0FF00FF0);

    // The NOP word (funct 0) decodes as ADD.
    applyStimulus(1'b0, 32'h00000000, 32'h4, 32'd4, 32'd6, 32'd100);
    checkOutput("nop_alu", ALUo, 32'd10);

    // ori uses Immi as B and ignores Bi.
    applyStimulus(1'b0, 32'h352800FF, 32'h4, 32'h0000F000, 32'h0000DEAD, 32'h000000FF);
    checkOutput("ori_alu", ALUo, 32'h0000F0FF);
    checkOutput("ori_b", Bo, 32'h000000FF);
    checkOutput("ori_isalur", {31'b0, isALUR}, 32'd0);
    checkOutput("ori_isbr", {31'b0, isBranch}, 32'd0);

    // slti is signed: -2 < 1.
    applyStimulus(1'b0, 32'h29280001, 32'h4, 32'hFFFFFFFE, 32'h0, 32'h00000001);
    checkOutput("slti_alu", ALUo, 32'h1);

    // beq target: NPC + Imm*4.
    // cond is checked before the falling edge.
    @(posedge clk);
    rst = 1'b0; IRi = 32'h1000FFFE; NPCi = 32'h40; Ai = 32'h0; Bi = 32'h77; Immi = 32'hFFFFFFFE;
    #1;
    checkOutput("beq_cond1", {31'b0, cond}, 32'd1);
    Ai = 32'd3;
    #1;
    checkOutput("beq_cond0", {31'b0, cond}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("beq_alu", ALUo, 32'h00000038);
    checkOutput("beq_b", Bo, 32'hFFFFFFF8);
    checkOutput("beq_isbr", {31'b0, isBranch}, 32'd1);
    checkOutput("beq_isalur", {31'b0, isALUR}, 32'd0);

    // bne is also a branch.
    applyStimulus(1'b0, 32'h14000003, 32'h100, 32'h5, 32'h0, 32'h3);
    checkOutput("bne_alu", ALUo, 32'h10C);
    checkOutput("bne_isbr", {31'b0, isBranch}, 32'd1);

    // j is a non-R, non-branch instruction that decodes as ADD on Ai + Immi.
    applyStimulus(1'b0, 32'h08000010, 32'h4, 32'd2, 32'd50, 32'd3);
    checkOutput("j_alu", ALUo, 32'd5);
    checkOutput("j_isbr", {31'b0, isBranch}, 32'd0);

    // Back-to-back add then lw, then reset with lw still on the inputs.
    applyStimulus(1'b0, 32'h012A4020, 32'h4, 32'd1, 32'd2, 32'h0);
    checkOutput("b2b_add", ALUo, 32'd3);
    applyStimulus(1'b0, 32'h8C000008, 32'h8, 32'h100, 32'h9, 32'h8);
    checkOutput("b2b_lw", ALUo, 32'h108);
    checkOutput("b2b_lw_b", Bo, 32'h8);
    applyStimulus(1'b1, 32'h8C000008, 32'h8, 32'h100, 32'h9, 32'h8);
    checkOutput("rst2_alu", ALUo, 32'h0);
    checkOutput("rst2_zf", {31'b0, ZFo}, 32'd1);
    checkOutput("rst2_b", Bo, 32'h0);
    checkOutput("rst2_ir", IRo, 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule

// File: doc/simple_alu_ins_analyser.md
Name: simple_alu_ins_analyser

Overview:
Execute-stage core of the R/I/J pipelined CPU. It decodes the instruction word (class flags and a 3-bit ALU operation) and selects the ALU operands. It latches the stage inputs into operand registers and computes a combinational 32-bit ALU result with zero and overflow flags. It sits between the ID/EX latch and the MEM stage.

Parameters:
None (32-bit datapath fixed).

Ports:
clk    in   1   stage clock; registers update on the falling edge (pipeline convention)
rst    in   1   synchronous, active-high reset
IRi    in   32  instruction from ID stage
NPCi   in   32  next PC (PC+4) of that instruction
Ai     in   32  rs register value
Bi     in   32  rt register value
Immi   in   32  sign/zero-extended immediate from ID
cond   out  1   branch condition, combinational: 1 iff Ai == 0
ALUo   out  32  ALU result F
ZFo    out  1   1 iff ALUo == 0
OFo    out  1   signed overflow (ADD/SUB only, else 0)
Bo     out  32  latched B operand
IRo    out  32  latched instruction
isALUR out  1   latched IR is R-type ALU (opcode 000000)
isBranch out 1  latched IR is beq (000100) or bne (000101)

Behaviour:
- Registers: A, B, IR (32 b), ALU_OP (3 b). Updated only on falling edge of clk.
- rst=1 at a falling edge: A, B, IR, ALU_OP <= 0. Reset overrides all loads. After reset, ALUo=0, ZFo=1, OFo=0, Bo=0, IRo=0, isALUR=1 (IR=0 decodes as R-type), isBranch=0.
- rst=0 at a falling edge: IR <= IRi. Operand selection uses the decode of IRi, the incoming word, not the stale IR.
  - A <= NPCi if IRi is a branch, else Ai.
  - B <= Bi if IRi is R-type; (Immi << 2), truncated to 32 b, if branch; else Immi.
  - ALU_OP <= decode(IRi).
- ALU_OP encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLT (signed; F = {31'b0, A<B}), 110 SUB (A-B), 111 SLTU (unsigned).
- Decode of R-type (opcode 000000), by funct IR[5:0]:
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU.
  - Any other funct, including the NOP word 0: ADD.
- Decode of I-type, by opcode:
  - ADD: 001000/001001 (addi/addiu), 100011 (lw), 101011 (sw), 000100/000101 (branches, target = NPC + Imm*4).
  - AND: 001100. OR: 001101. XOR: 001110. SLT: 001010. SLTU: 001011.
  - Any other opcode (e.g. j 000010): ADD, non-R, non-branch.
- isALUR and isBranch outputs decode the latched IR, combinationally.
- ALUo, ZFo, OFo are purely combinational from A, B, ALU_OP: zero latency after the edge.
- OF rules:
  - ADD: OF = (A[31]==B[31]) && (F[31]!=A[31]).
  - SUB: OF = (A[31]!=B[31]) && (F[31]!=A[31]).
  - All other ops: OF = 0.
- Arithmetic wraps modulo 2^32; no carry output.
- cond is combinational from the Ai input (not latched). It is evaluated by the caller in the same half-cycle the branch enters the stage.

Test Plan:
- Reset: rst=1 for one falling edge, with IRi=0x012A4020 and Ai=5 -> ALUo=0, ZFo=1, OFo=0, IRo=0, Bo=0.
- R-type add: IRi=0x012A4020 (add), Ai=0x7FFFFFFF, Bi=1 -> after edge ALUo=0x80000000, OFo=1, ZFo=0, isALUR=1, Bo=1.
- R-type sub/slt:
  - funct 100010, Ai=5, Bi=5 -> ALUo=0, ZFo=1, OFo=0.
  - funct 101010, Ai=0xFFFFFFFF, Bi=1 -> ALUo=1.
  - funct 101011, same operands -> ALUo=0.
- I-type ori: opcode 001101, Ai=0x0000F000, Bi=0xDEAD, Immi=0x000000FF -> ALUo=0x0000F0FF, Bo=0x000000FF, isALUR=0.
- Branch target: opcode 000100, NPCi=0x00000040, Immi=0xFFFFFFFE, Ai=0 -> cond=1 before the edge; after the edge ALUo=0x00000038, isBranch=1. With Ai=3 -> cond=0.
- Back-to-back then reset: add followed by lw (Ai=0x100, Immi=8) on consecutive edges -> ALUo=0x108. Then assert rst -> all registers 0 on that edge.
